// File: rtl/pulse_receiver_pkg.sv
// Shared definitions for the pulse receiver and its matching pulse generator.
package pulse_receiver_pkg;

  // Default frame width, shared with the transmitting pulse generator
  localparam int PULSE_WIDTH = 8;

  // Receiver FSM state encoding (single bit, legacy compatible)
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

endpackage

// File: rtl/pulse_receiver_if.sv
// Bus bundle between the pulse receiver and its producer/consumer.
// The master side drives the serial stream and the acknowledge; the
// slave side (the receiver) returns the captured word and status.
interface pulse_receiver_if #(
  parameter int WIDTH = pulse_receiver_pkg::PULSE_WIDTH
);

  logic             serial_in;
  logic             frame_start;
  logic             data_ack;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             overrun;
  logic             busy;

  modport master (
    output serial_in, frame_start, data_ack,
    input  data, data_valid, overrun, busy
  );

  modport slave (
    input  serial_in, frame_start, data_ack,
    output data, data_valid, overrun, busy
  );

endinterface

// File: rtl/pulse_receiver_sipo_shift_reg.sv
// Shifting datapath of the pulse receiver. Shifts left (inserting at the
// LSB) when the first serial bit is the MSB, otherwise shifts right
// (inserting at the MSB).
module sipo_shift_reg import pulse_receiver_pkg::*; #(
  parameter int WIDTH     = PULSE_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Clr_not,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next shift-register value in the configured bit order
  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], serial_in};
      end else begin
        sr_d = {serial_in, sr_q[WIDTH-1:1]};
      end
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift-register state, cleared asynchronously
  always_ff @(posedge Clk or negedge Clr_not) begin
    if (!Clr_not) begin
      sr_q <= {WIDTH{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/pulse_receiver.sv
// Serial-in, parallel-out frame receiver. Reassembles a WIDTH-bit frame
// that begins with a frame_start strobe, then hands the word to a holding
// register guarded by a valid/ack handshake with a sticky overrun flag.
module pulse_receiver import pulse_receiver_pkg::*; #(
  parameter int WIDTH     = PULSE_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              Clk,
  input logic              Clr_not,
  pulse_receiver_if.slave  rx
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;

  logic             shift_en_s;
  logic             complete_s;
  logic [WIDTH-1:0] sr_s;
  logic [WIDTH-1:0] word_s;
  logic             unused_ends_s;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sipo (
    .Clk       (Clk),
    .Clr_not   (Clr_not),
    .shift_en  (shift_en_s),
    .serial_in (rx.serial_in),
    .q         (sr_s)
  );

  // Complete word = bits already shifted in plus the bit on the wire now
  always_comb begin
    if (MSB_FIRST) begin
      word_s = {sr_s[WIDTH-2:0], rx.serial_in};
    end else begin
      word_s = {rx.serial_in, sr_s[WIDTH-1:1]};
    end
  end

  // The oldest register bit falls off the word in either bit order
  assign unused_ends_s = sr_s[WIDTH-1] ^ sr_s[0];

  // Frame FSM and bit counter; frame_start is only honoured in IDLE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    shift_en_s = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx.frame_start) begin
          shift_en_s = 1'b1;
          cnt_d      = CNT_W'(1);
          state_d    = SHIFT;
          busy_d     = 1'b1;
        end else begin
          state_d    = IDLE;
          busy_d     = 1'b0;
        end
      end
      SHIFT: begin
        shift_en_s = 1'b1;
        if (cnt_q == LAST_CNT) begin
          complete_s = 1'b1;
          cnt_d      = {CNT_W{1'b0}};
          state_d    = IDLE;
          busy_d     = 1'b0;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = SHIFT;
          busy_d     = 1'b1;
        end
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Holding register and handshake; an ack in the completion cycle
  // consumes the old word, so that completion does not raise overrun
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (complete_s) begin
      data_d  = word_s;
      valid_d = 1'b1;
      if (rx.data_ack) begin
        ovr_d = 1'b0;
      end else if (valid_q) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
    end else if (rx.data_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
      ovr_d   = ovr_q;
    end
  end

  // All receiver state; a reset discards any partial frame
  always_ff @(posedge Clk or negedge Clr_not) begin
    if (!Clr_not) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx.data       = data_q;
  assign rx.data_valid = valid_q;
  assign rx.overrun    = ovr_q;
  assign rx.busy       = busy_q;

endmodule

// File: tb/tb_pulse_receiver.sv
// Bench for pulse_receiver: one MSB-first and one LSB-first instance are
// fed the same frames (each in its own bit order), so both must yield the
// same words. Expected words are queued as frames are sent and compared
// when busy falls at frame completion.
module tb_pulse_receiver;
  import pulse_receiver_pkg::*;

  logic Clk     = 1'b0;
  logic Clr_not = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];
  logic       prev_busy_m = 1'b0;
  logic       prev_busy_l = 1'b0;

  pulse_receiver_if #(.WIDTH(PULSE_WIDTH)) rx_m ();
  pulse_receiver_if #(.WIDTH(PULSE_WIDTH)) rx_l ();

  pulse_receiver #(.WIDTH(PULSE_WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .Clk(Clk), .Clr_not(Clr_not), .rx(rx_m)
  );

  pulse_receiver #(.WIDTH(PULSE_WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .Clk(Clk), .Clr_not(Clr_not), .rx(rx_l)
  );

  always #5 Clk = ~Clk;

  // Scoreboard monitor: a falling busy marks a completed frame
  always @(posedge Clk) begin
    logic [7:0] w;
    #1;
    if (Clr_not !== 1'b1) begin
      prev_busy_m = 1'b0;
      prev_busy_l = 1'b0;
    end else begin
      if (prev_busy_m === 1'b1 && rx_m.busy === 1'b0) begin
        checks++;
        if (exp_m.size() == 0) begin
          errors++;
          $display("FAIL sb_msb_unexpected: got data=%h with no word expected", rx_m.data);
        end else begin
          w = exp_m.pop_front();
          if (rx_m.data !== w || rx_m.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL sb_msb_word: got data=%h valid=%b, need data=%h valid=1", rx_m.data, rx_m.data_valid, w);
          end
        end
      end
      if (prev_busy_l === 1'b1 && rx_l.busy === 1'b0) begin
        checks++;
        if (exp_l.size() == 0) begin
          errors++;
          $display("FAIL sb_lsb_unexpected: got data=%h with no word expected", rx_l.data);
        end else begin
          w = exp_l.pop_front();
          if (rx_l.data !== w || rx_l.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL sb_lsb_word: got data=%h valid=%b, need data=%h valid=1", rx_l.data, rx_l.data_valid, w);
          end
        end
      end
      prev_busy_m = rx_m.busy;
      prev_busy_l = rx_l.busy;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic sm, input logic sl, input logic ack);
    rx_m.frame_start = fs;
    rx_l.frame_start = fs;
    rx_m.serial_in   = sm;
    rx_l.serial_in   = sl;
    rx_m.data_ack    = ack;
    rx_l.data_ack    = ack;
  endtask

  // Sends word w over cycles 0..7; fs_noise adds extra frame_start pulses,
  // ack_at selects a cycle carrying data_ack (-1 for none). Returns at cycle 8.
  task automatic send_frame(input logic [7:0] w, input logic [7:0] fs_noise, input int ack_at);
    exp_m.push_back(w);
    exp_l.push_back(w);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        checks++;
        if (rx_m.busy !== 1'b1 || rx_l.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid_frame cycle %0d: got msb=%b lsb=%b, need 1", i, rx_m.busy, rx_l.busy);
        end
      end
      drive((i == 0) || fs_noise[i], w[7-i], w[i], (i == ack_at));
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++;
      if ({rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy, rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy} !== 22'd0) begin
        errors++;
        $display("FAIL reset_hold: got msb=%h/%b%b%b lsb=%h/%b%b%b, need all 0", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy, rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Clr_not = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'b0);
      tick();
      checks++;
      if ({rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy, rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy} !== 22'd0) begin
        errors++;
        $display("FAIL reset_idle: got msb=%h/%b%b%b lsb=%h/%b%b%b, need all 0", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy, rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy);
      end
    end
  endtask

  task automatic test_single_frame();
    send_frame(8'hB2, 8'h00, -1);
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy} !== {8'hB2, 1'b1, 1'b0, 1'b0} ||
        {rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy} !== {8'hB2, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_c8: got msb=%h/%b%b%b lsb=%h/%b%b%b, need B2/100", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy, rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (rx_m.data_valid !== 1'b1 || rx_l.data_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_c10_valid: got msb=%b lsb=%b, need 1", rx_m.data_valid, rx_l.data_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun} !== {8'hB2, 1'b0, 1'b0} ||
        {rx_l.data, rx_l.data_valid, rx_l.overrun} !== {8'hB2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_ack: got msb=%h/%b%b lsb=%h/%b%b, need B2/00", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_l.data, rx_l.data_valid, rx_l.overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_frame(8'hB2, 8'h00, -1);
    send_frame(8'h5A, 8'h00, -1);
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun} !== {8'h5A, 1'b1, 1'b1} ||
        {rx_l.data, rx_l.data_valid, rx_l.overrun} !== {8'h5A, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_overrun: got msb=%h/%b%b lsb=%h/%b%b, need 5A/11", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_l.data, rx_l.data_valid, rx_l.overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (rx_m.overrun !== 1'b1 || rx_l.overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sticky: got msb=%b lsb=%b, need 1", rx_m.overrun, rx_l.overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun} !== {8'h5A, 1'b0, 1'b0} ||
        {rx_l.data, rx_l.data_valid, rx_l.overrun} !== {8'h5A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_ack: got msb=%h/%b%b lsb=%h/%b%b, need 5A/00", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_l.data, rx_l.data_valid, rx_l.overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ack_coincident();
    send_frame(8'hB2, 8'h00, -1);
    send_frame(8'h5A, 8'h00, 7);
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun} !== {8'h5A, 1'b1, 1'b0} ||
        {rx_l.data, rx_l.data_valid, rx_l.overrun} !== {8'h5A, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ack_coincident: got msb=%h/%b%b lsb=%h/%b%b, need 5A/10", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_l.data, rx_l.data_valid, rx_l.overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (rx_m.data_valid !== 1'b0 || rx_l.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_coincident_clear: got msb=%b lsb=%b, need 0", rx_m.data_valid, rx_l.data_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_robustness();
    logic [7:0] w;
    send_frame(8'h96, 8'h88, -1);
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy} !== {8'h96, 1'b1, 1'b0, 1'b0} ||
        {rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy} !== {8'h96, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fs_ignored: got msb=%h/%b%b%b lsb=%h/%b%b%b, need 96/100", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy, rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy);
    end
    w = 8'h6D;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, w[7-i], w[i], 1'b0);
      tick();
    end
    drive(1'b0, w[3], w[4], 1'b0);
    #2;
    Clr_not = 1'b0;
    #1;
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy, rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got msb=%h/%b%b%b lsb=%h/%b%b%b, need all 0", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_m.busy, rx_l.data, rx_l.data_valid, rx_l.overrun, rx_l.busy);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Clr_not = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      checks++;
      if ({rx_m.data_valid, rx_m.busy, rx_l.data_valid, rx_l.busy} !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset_idle: got msb v/b=%b%b lsb v/b=%b%b, need 00", rx_m.data_valid, rx_m.busy, rx_l.data_valid, rx_l.busy);
      end
    end
    send_frame(8'h3C, 8'h00, -1);
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun} !== {8'h3C, 1'b1, 1'b0} ||
        {rx_l.data, rx_l.data_valid, rx_l.overrun} !== {8'h3C, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fresh_frame: got msb=%h/%b%b lsb=%h/%b%b, need 3C/10", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_l.data, rx_l.data_valid, rx_l.overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_lsb_first();
    logic [7:0] gen_m;
    logic [7:0] gen_l;
    // LSB instance sees 0,1,0,0,1,1,0,1
    send_frame(8'hB2, 8'h00, -1);
    checks++;
    if (rx_l.data !== 8'hB2 || rx_l.data_valid !== 1'b1) begin
      errors++;
      $display("FAIL lsb_bits: got data=%h valid=%b, need B2/1", rx_l.data, rx_l.data_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    // Pulse-generator loopback: parallel load, then shift out one bit per cycle
    gen_m = 8'hA7;
    gen_l = 8'hA7;
    exp_m.push_back(8'hA7);
    exp_l.push_back(8'hA7);
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, gen_m[7], gen_l[0], 1'b0);
      gen_m = gen_m << 1;
      gen_l = gen_l >> 1;
      tick();
    end
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun} !== {8'hA7, 1'b1, 1'b0} ||
        {rx_l.data, rx_l.data_valid, rx_l.overrun} !== {8'hA7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL loopback: got msb=%h/%b%b lsb=%h/%b%b, need A7/10", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_l.data, rx_l.data_valid, rx_l.overrun);
    end
    send_frame(8'h0F, 8'h00, -1);
    checks++;
    if ({rx_m.data, rx_m.overrun, rx_l.data, rx_l.overrun} !== {8'h0F, 1'b1, 8'h0F, 1'b1}) begin
      errors++;
      $display("FAIL overrun_second: got msb=%h/%b lsb=%h/%b, need 0F/1", rx_m.data, rx_m.overrun, rx_l.data, rx_l.overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if ({rx_m.data, rx_m.data_valid, rx_m.overrun} !== {8'h0F, 1'b0, 1'b0} ||
        {rx_l.data, rx_l.data_valid, rx_l.overrun} !== {8'h0F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_ack: got msb=%h/%b%b lsb=%h/%b%b, need 0F/00", rx_m.data, rx_m.data_valid, rx_m.overrun, rx_l.data, rx_l.data_valid, rx_l.overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, need finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ack_coincident();
    test_robustness();
    test_lsb_first();
    checks++;
    if (exp_m.size() != 0 || exp_l.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d/%0d words left, need 0", exp_m.size(), exp_l.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_receiver.md
Name: pulse_receiver

Overview:
Serial-in, parallel-out (SIPO) capture block. It is the receiving end of the team's 8-bit parallel-load pulse generator: it reassembles the serial bit stream into a parallel word. A frame-start strobe marks the first bit of each frame. Completed words go to a holding register with a valid/ack handshake, so a new frame can shift in while the consumer still holds the previous word. Overrun is flagged when an unread word is overwritten.

Parameters:
WIDTH, 8, frame length in bits and width of data; legal range 2..32.
MSB_FIRST, 1, 1 = first serial bit lands in data[WIDTH-1] (matches the pulse generator); 0 = first bit lands in data[0].

Ports:
Clk  input  1  single clock; all state changes on the rising edge.
Clr_not  input  1  asynchronous, active-low reset.
serial_in  input  1  serial data bit, sampled on every rising edge of Clk.
frame_start  input  1  high in the cycle that carries bit 0 of a frame; only recognised in IDLE.
data_ack  input  1  consumer acknowledge; clears data_valid on the next edge.
data  output  WIDTH  last completed word; registered; held until the next frame completes.
data_valid  output  1  high while data holds an unacknowledged word.
overrun  output  1  sticky; set when a word completes while data_valid=1 and data_ack=0.
busy  output  1  registered; high while a frame is partially received (state SHIFT).

Behaviour:
- Reset (Clr_not=0, asynchronous): state=IDLE, bit count=0, shift register=0, data=0, data_valid=0, overrun=0, busy=0.
- A reset mid-frame discards the partial word. Reception resumes only on a new frame_start after reset is released.
- IDLE:
  - If frame_start=1, sample serial_in as frame bit 0, set count=1, go to SHIFT.
  - Otherwise hold; serial_in is ignored.
- SHIFT:
  - Sample serial_in every cycle and increment count.
  - frame_start is ignored in SHIFT, including in the last-bit cycle.
  - On the cycle count==WIDTH-1, the edge samples the last bit and loads the complete word (shift register plus this bit) into data. State returns to IDLE and count resets to 0.
- Latency: with frame_start in cycle 0, bits occupy cycles 0..WIDTH-1.
  - busy=1 in cycles 1..WIDTH-1.
  - data and data_valid update at the end of cycle WIDTH-1 and are visible from cycle WIDTH.
- Back-to-back frames: frame_start is accepted in cycle WIDTH (zero gap), because the state is already IDLE.
- Bit order:
  - MSB_FIRST=1: frame bit i goes to data[WIDTH-1-i]; the register shifts left, inserting at the LSB.
  - MSB_FIRST=0: frame bit i goes to data[i]; the register shifts right, inserting at the MSB.
- Handshake:
  - data_ack=1 with no completion in the same cycle: data_valid goes to 0 and overrun goes to 0 next edge; data is unchanged.
  - data_ack while data_valid=0 has no effect, except clearing overrun.
- Completion rules:
  - Completion while data_valid=0: data_valid goes to 1.
  - Completion while data_valid=1 and data_ack=0: data is overwritten, data_valid stays 1, overrun goes to 1.
  - Completion in the same cycle as data_ack=1: the old word is consumed and the new word loads. data_valid stays 1 and overrun goes to 0 (the ack clears it; this completion does not set it).
- overrun is sticky: it is cleared only by data_ack or by reset.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package:
  - state encoding constants IDLE=1'b0, SHIFT=1'b1;
  - default frame width constant PULSE_WIDTH=8, also used by the pulse generator side.
- One sub-module: sipo_shift_reg (parameters WIDTH and MSB_FIRST; ports Clk, Clr_not, shift_en, serial_in, q[WIDTH-1:0]). It holds the shifting datapath.
- The FSM, bit counter (width clog2(WIDTH)), holding register and handshake logic stay in pulse_receiver.

Test Plan:
1. Reset: hold Clr_not=0 with random inputs, then release → data=0, data_valid=0, overrun=0, busy=0; no activity without frame_start.
2. Single frame: frame_start in cycle 0; serial bits 1,0,1,1,0,0,1,0 in cycles 0..7 (MSB_FIRST=1) → busy=1 in cycles 1..7; data=8'hB2 and data_valid=1 from cycle 8; data_ack in cycle 10 → data_valid=0 from cycle 11, data still 8'hB2.
3. Back-to-back with overrun: frame 8'hB2 (cycles 0..7), then frame_start in cycle 8 sending 8'h5A, no ack → data=8'h5A, data_valid=1, overrun=1 at cycle 16; data_ack in cycle 17 → data_valid=0, overrun=0 in cycle 18.
4. Ack coincident with completion: same as scenario 3 but data_ack=1 in cycle 15 → cycle 16: data=8'h5A, data_valid=1, overrun=0.
5. Robustness: frame_start pulses in cycles 3 and 7 of a frame are ignored and the frame completes correctly. In the next frame, Clr_not=0 in cycle 4 → all outputs 0 immediately (asynchronous). A fresh frame 8'h3C is then received correctly.
6. MSB_FIRST=0: serial bits 0,1,0,0,1,1,0,1 → data=8'hB2 at cycle 8; pulse-generator loopback loaded with 8'hA7 → receiver data=8'hA7.
